peripheral_adder_arbiter: RTL
=============================

PERIPHERAL_ADDER_ARBITER -- requirements
Module: peripheral_adder_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing the adder (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, operand width; result width is DATA_WIDTH+1.
REQ-003 SHALL use one clock and one reset: reset is asynchronous and active-low.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  NUM_REQ  per-requester operation request.
REQ-007 req_ip1  input  NUM_REQ*DATA_WIDTH  packed first operands; requester i in slice i.
REQ-008 req_ip2  input  NUM_REQ*DATA_WIDTH  packed second operands; requester i in slice i.
REQ-009 req_ready  output  NUM_REQ  one-hot grant/accept strobe.
REQ-010 rsp_valid  output  1  result available.
REQ-011 rsp_id  output  $clog2(NUM_REQ)  index of the requester owning the result.
REQ-012 rsp_out  output  DATA_WIDTH+1  unsigned sum including carry.
REQ-013 rsp_ready  input  1  consumer accepts the result.
REQ-014 busy  output  1  high whenever the state is not IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, CALC and RESP.
REQ-016 IDLE: if any req_valid is set, SHALL select one requester, assert its req_ready combinationally in that cycle, capture its operands and index, and enter CALC; otherwise remain in IDLE.
REQ-017 req_ready SHALL be zero in every cycle outside IDLE and at most one bit SHALL be set.
REQ-018 CALC: SHALL register rsp_out = zero-extended ip1 + zero-extended ip2 (no overflow loss) and enter RESP.
REQ-019 RESP: SHALL hold rsp_valid=1 with stable rsp_out and rsp_id until rsp_ready=1; on that cycle return to IDLE.
REQ-020 Latency from the accept cycle to the first rsp_valid cycle SHALL be exactly 2 cycles; maximum throughput is one operation per 3 cycles.
REQ-021 A requester dropping req_valid while not granted SHALL be ignored; operand changes after acceptance SHALL NOT affect the result.
REQ-022 Arbitration pointer SHALL advance to (granted index + 1) mod NUM_REQ only on a grant.
REQ-023 With rsp_ready held low, the block SHALL stall in RESP indefinitely, with no grants issued.
REQ-024 Sum 0xFF+0xFF SHALL produce rsp_out=0x1FE; 0x00+0x00 SHALL produce 0x000.

Reset
REQ-025 On rst low, SHALL asynchronously enter IDLE, clear rsp_valid, rsp_out, rsp_id, busy and req_ready, and set the arbitration pointer to 0.
REQ-026 Reset asserted in CALC or RESP SHALL discard the in-flight result; no rsp_valid SHALL appear after release without a new grant.
REQ-027 First grant after reset release SHALL occur no earlier than the first rising edge with rst high.

Configuration
REQ-028 Macro PERIPHERAL_ADDER_ARBITER_ROUND_ROBIN_EN SHALL select the arbitration policy.
REQ-029 Defined: round-robin; search starts at the pointer and wraps from NUM_REQ-1 to 0.
REQ-030 Undefined: fixed priority, lowest index wins; the pointer is not implemented; REQ-022 does not apply.

Verification
REQ-031 Single request: req_valid=0001, ip1[0]=0x12, ip2[0]=0x34 -> req_ready=0001 same cycle; 2 cycles later rsp_valid=1, rsp_id=0, rsp_out=0x046.
REQ-032 Carry: requester 2, 0xFF+0x01 -> rsp_id=2, rsp_out=0x100.
REQ-033 All four valid continuously, rsp_ready=1, round-robin defined -> grant order 0,1,2,3,0; without the macro -> 0,0,0.
REQ-034 Backpressure: rsp_ready=0 for 10 cycles in RESP -> rsp_out and rsp_id stable, req_ready=0000, busy=1 throughout.
REQ-035 Reset in RESP: drive rst low for 1 cycle -> rsp_valid=0, busy=0 immediately; the next grant goes to requester 0.
REQ-036 Operand change: alter ip1[1] from 0x10 to 0x20 one cycle after accept with ip2=0x01 -> rsp_out=0x011.

Source files
------------

// File: rtl/peripheral_adder_arbiter.sv
// peripheral_adder_arbiter: shares one registered adder among NUM_REQ requesters.
// Define PERIPHERAL_ADDER_ARBITER_ROUND_ROBIN_EN for round-robin arbitration; otherwise lowest index wins.
module peripheral_adder_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_ip1,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_ip2,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
  output logic [DATA_WIDTH:0]           rsp_out,
  input  logic                          rsp_ready,
  output logic                          busy
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;
  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] ip1_q, ip2_q;
  logic [DATA_WIDTH:0]   sum_q;
  logic [IW-1:0]         id_q, sel;
  logic                  found, grant;
`ifdef PERIPHERAL_ADDER_ARBITER_ROUND_ROBIN_EN
  logic [IW-1:0]         ptr_q;
  int                    idx;
  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        sel   = IW'(idx);
      end
    end
  end
`else
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[k]) begin
        found = 1'b1;
        sel   = IW'(k);
      end
    end
  end
`endif
  // rst is folded in so no strobe leaks out while reset is held
  assign grant = rst && state_q == IDLE && found;
  always_comb begin
    req_ready = '0;
    if (grant) req_ready[sel] = 1'b1;
    state_d = (state_q == IDLE) ? (found ? CALC : IDLE) :
              (state_q == CALC) ? RESP :
              (rsp_ready ? IDLE : RESP);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ip1_q   <= '0;
      ip2_q   <= '0;
      id_q    <= '0;
      sum_q   <= '0;
`ifdef PERIPHERAL_ADDER_ARBITER_ROUND_ROBIN_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (grant) begin
        ip1_q <= req_ip1[sel*DATA_WIDTH +: DATA_WIDTH];
        ip2_q <= req_ip2[sel*DATA_WIDTH +: DATA_WIDTH];
        id_q  <= sel;
`ifdef PERIPHERAL_ADDER_ARBITER_ROUND_ROBIN_EN
        ptr_q <= (int'(sel) == NUM_REQ - 1) ? '0 : sel + IW'(1);
`endif
      end
      if (state_q == CALC) sum_q <= {1'b0, ip1_q} + {1'b0, ip2_q};
    end
  end
  assign rsp_valid = state_q == RESP;
  assign busy      = state_q != IDLE;
  assign rsp_id    = id_q;
  assign rsp_out   = sum_q;
endmodule
